// File: rtl/itcm_arb.sv
// rtl/itcm_arb.sv - IFU/LSU arbiter and response sequencer for the single-port ITCM RAM.
// Optional fairness (starvation counter, forced IFU priority) enabled by ITCM_ARB_FAIRNESS_EN.
module itcm_arb #(
  parameter int AW         = 14,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_req_we,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [DW-1:0] lsu_req_wdata,
  input  logic [MW-1:0] lsu_req_wem,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("itcm_arb: STARVE_MAX must be in 1..15");
  end

  logic          ifu_pend, ifu_hold;
  logic [DW-1:0] ifu_hold_data;
  logic          lsu_pend, lsu_hold, lsu_pend_wr;
  logic [DW-1:0] lsu_hold_data;
  logic [DW-1:0] lsu_live_data;
  logic          ifu_elig, lsu_elig, starved;
  logic          gnt_ifu, gnt_lsu;

  assign ifu_rsp_valid = ifu_pend | ifu_hold;
  assign lsu_rsp_valid = lsu_pend | lsu_hold;
  assign ifu_rsp_rdata = ifu_hold ? ifu_hold_data : ram_dout;
  assign lsu_live_data = lsu_pend_wr ? '0 : ram_dout;
  assign lsu_rsp_rdata = lsu_hold ? lsu_hold_data : lsu_live_data;

  // A slot being drained this cycle is not blocked, so the port can re-issue immediately.
  assign ifu_elig = ifu_req_valid & ~(ifu_rsp_valid & ~ifu_rsp_ready) & ~rst;
  assign lsu_elig = lsu_req_valid & ~(lsu_rsp_valid & ~lsu_rsp_ready) & ~rst;

  assign gnt_ifu = ifu_elig & (starved | ~lsu_elig);
  assign gnt_lsu = lsu_elig & ~gnt_ifu;

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;

  assign ram_we   = gnt_lsu & lsu_req_we;
  assign ram_addr = gnt_ifu ? ifu_req_addr : lsu_req_addr;
  assign ram_din  = lsu_req_wdata;
  assign ram_wem  = ram_we ? lsu_req_wem : '0;

`ifdef ITCM_ARB_FAIRNESS_EN
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign starved = (starve_cnt == SMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt_ifu) begin
      starve_cnt <= '0;
    end else if (ifu_req_valid && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_pend      <= 1'b0;
      ifu_hold      <= 1'b0;
      ifu_hold_data <= '0;
    end else begin
      ifu_pend <= gnt_ifu;
      if (ifu_rsp_ready) begin
        ifu_hold <= 1'b0;
      end else if (ifu_pend) begin
        ifu_hold      <= 1'b1;
        ifu_hold_data <= ram_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_pend      <= 1'b0;
      lsu_pend_wr   <= 1'b0;
      lsu_hold      <= 1'b0;
      lsu_hold_data <= '0;
    end else begin
      lsu_pend    <= gnt_lsu;
      lsu_pend_wr <= gnt_lsu & lsu_req_we;
      if (lsu_rsp_ready) begin
        lsu_hold <= 1'b0;
      end else if (lsu_pend) begin
        lsu_hold      <= 1'b1;
        lsu_hold_data <= lsu_live_data;
      end
    end
  end

endmodule

// File: tb/tb_itcm_arb.sv
// tb/tb_itcm_arb.sv - self-checking bench for itcm_arb with a behavioural RAM and reference model.
module tb_itcm_arb;
  localparam int AW = 14, DW = 32, MW = 4, SMAX = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, lsu_rsp_ready;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
  logic [MW-1:0] lsu_req_wem;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [MW-1:0] ram_wem;

  int vectors = 0, miscompares = 0;

  itcm_arb #(.AW(AW), .DW(DW), .MW(MW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wem(lsu_req_wem),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wem(ram_wem), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAAAAAAAA;
    return 32'hC0DE0000 | i;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] wem);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (wem[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM: 64 words, one-cycle read latency, reloaded while rst is high.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr[5:0]] <= merge(mem[ram_addr[5:0]], ram_din, ram_wem);
      ram_dout <= mem[ram_addr[5:0]];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic iv, logic [13:0] ia, logic irr, logic lv, logic lwe,
                       logic [13:0] la, logic [31:0] lwd, logic [3:0] lwem, logic lrr);
    ifu_req_valid = iv; ifu_req_addr = ia; ifu_rsp_ready = irr;
    lsu_req_valid = lv; lsu_req_we = lwe; lsu_req_addr = la;
    lsu_req_wdata = lwd; lsu_req_wem = lwem; lsu_rsp_ready = lrr;
  endtask

  typedef struct {
    logic iv; logic [13:0] ia; logic irr;
    logic lv; logic lwe; logic [13:0] la; logic [31:0] lwd; logic [3:0] lwem; logic lrr;
    logic e_ir; logic e_lr; logic e_iv; logic [31:0] e_id; logic e_lv; logic [31:0] e_ld;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [13:0] ia, logic irr, logic lv, logic lwe,
                              logic [13:0] la, logic [31:0] lwd, logic [3:0] lwem, logic lrr,
                              logic e_ir, logic e_lr, logic e_iv, logic [31:0] e_id,
                              logic e_lv, logic [31:0] e_ld);
    vec_t v;
    v.iv = iv; v.ia = ia; v.irr = irr; v.lv = lv; v.lwe = lwe; v.la = la; v.lwd = lwd;
    v.lwem = lwem; v.lrr = lrr; v.e_ir = e_ir; v.e_lr = e_lr; v.e_iv = e_iv; v.e_id = e_id;
    v.e_lv = e_lv; v.e_ld = e_ld;
    return v;
  endfunction

  vec_t tbl [12];
  logic [31:0] refmem [0:63];
  logic [31:0] iq [$], lq [$];
  int starve;

  initial begin
    // Directed single-cycle rows; state carries from one row to the next.
    tbl[0]  = mk(1, 14'h10, 1, 0, 0, 0,      0,            0, 1,  1, 0, 0, 0,            0, 0);
    tbl[1]  = mk(0, 0,      1, 0, 0, 0,      0,            0, 1,  0, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(0, 0,      1, 1, 1, 14'h20, 32'h12345678, 3, 1,  0, 1, 0, 0,            0, 0);
    tbl[3]  = mk(0, 0,      1, 1, 0, 14'h20, 0,            0, 1,  0, 1, 0, 0,            1, 0);
    tbl[4]  = mk(0, 0,      1, 0, 0, 0,      0,            0, 1,  0, 0, 0, 0,            1, 32'hAAAA5678);
    tbl[5]  = mk(1, 14'h10, 0, 0, 0, 0,      0,            0, 1,  1, 0, 0, 0,            0, 0);
    tbl[6]  = mk(1, 14'h10, 0, 1, 0, 14'h20, 0,            0, 1,  0, 1, 1, 32'hDEADBEEF, 0, 0);
    tbl[7]  = mk(1, 14'h10, 0, 1, 0, 14'h10, 0,            0, 1,  0, 1, 1, 32'hDEADBEEF, 1, 32'hAAAA5678);
    tbl[8]  = mk(1, 14'h10, 0, 0, 0, 0,      0,            0, 1,  0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    tbl[9]  = mk(1, 14'h20, 1, 0, 0, 0,      0,            0, 1,  1, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[10] = mk(0, 0,      1, 0, 0, 0,      0,            0, 1,  0, 0, 1, 32'hAAAA5678, 0, 0);
    tbl[11] = mk(0, 0,      1, 0, 0, 0,      0,            0, 1,  0, 0, 0, 0,            0, 0);

    // Reset state with both requesters asserting.
    drive(1, 14'h10, 1, 1, 1, 14'h20, 32'hFFFFFFFF, 4'hF, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].iv, tbl[r].ia, tbl[r].irr, tbl[r].lv, tbl[r].lwe, tbl[r].la,
            tbl[r].lwd, tbl[r].lwem, tbl[r].lrr);
      @(negedge clk);
      chk($sformatf("row%0d_ifu_ready", r), ifu_req_ready, tbl[r].e_ir);
      chk($sformatf("row%0d_lsu_ready", r), lsu_req_ready, tbl[r].e_lr);
      chk($sformatf("row%0d_ifu_rsp_valid", r), ifu_rsp_valid, tbl[r].e_iv);
      chk($sformatf("row%0d_lsu_rsp_valid", r), lsu_rsp_valid, tbl[r].e_lv);
      if (tbl[r].e_iv) chk($sformatf("row%0d_ifu_rdata", r), ifu_rsp_rdata, tbl[r].e_id);
      if (tbl[r].e_lv) chk($sformatf("row%0d_lsu_rdata", r), lsu_rsp_rdata, tbl[r].e_ld);
      @(posedge clk); #1;
    end

    // Both ports request every cycle.
    for (int i = 0; i < 10; i++) begin
      logic exp_ifu;
`ifdef ITCM_ARB_FAIRNESS_EN
      exp_ifu = (i % (SMAX + 1)) == SMAX;
`else
      exp_ifu = 1'b0;
`endif
      drive(1, 14'h1, 1, 1, 0, 14'h0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("fair%0d_ifu_ready", i), ifu_req_ready, exp_ifu);
      chk($sformatf("fair%0d_lsu_ready", i), lsu_req_ready, !exp_ifu);
      @(posedge clk); #1;
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk); #1;

    // Reset in the cycle after an accepted LSU read discards the response.
    drive(0, 0, 1, 1, 0, 14'h3, 0, 0, 1);
    @(negedge clk);
    chk("rstmid_accept", lsu_req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("rstmid_lsu_ready", lsu_req_ready, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_after%0d", i), lsu_rsp_valid, 0);
      @(posedge clk); #1;
    end

    // Back-to-back LSU reads of 0..7.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, i < 8, 0, 14'(i), 0, 0, 1);
      @(negedge clk);
      if (i < 8) chk($sformatf("b2b%0d_ready", i), lsu_req_ready, 1);
      chk($sformatf("b2b%0d_rsp_valid", i), lsu_rsp_valid, (i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) chk($sformatf("b2b%0d_rdata", i), lsu_rsp_rdata, init_val(i - 1));
      @(posedge clk); #1;
    end

    // Randomised traffic against the reference model.
    for (int i = 0; i < 64; i++) refmem[i] = init_val(i);
    starve = 0;
    for (int n = 0; n < 3000; n++) begin
      logic ev_i, ev_l, el_i, el_l, st, gi, gl;
      drive($urandom_range(0, 1), 14'($urandom_range(0, 63)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1), 14'($urandom_range(0, 63)),
            $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      ev_i = iq.size() > 0;
      ev_l = lq.size() > 0;
      el_i = ifu_req_valid && !(ev_i && !ifu_rsp_ready);
      el_l = lsu_req_valid && !(ev_l && !lsu_rsp_ready);
`ifdef ITCM_ARB_FAIRNESS_EN
      st = (starve == SMAX);
`else
      st = 1'b0;
`endif
      gi = el_i && (st || !el_l);
      gl = el_l && !gi;
      @(negedge clk);
      chk("rnd_ifu_ready", ifu_req_ready, gi);
      chk("rnd_lsu_ready", lsu_req_ready, gl);
      chk("rnd_ifu_rsp_valid", ifu_rsp_valid, ev_i);
      chk("rnd_lsu_rsp_valid", lsu_rsp_valid, ev_l);
      if (ev_i) chk("rnd_ifu_rdata", ifu_rsp_rdata, iq[0]);
      if (ev_l) chk("rnd_lsu_rdata", lsu_rsp_rdata, lq[0]);
      if (ev_i && ifu_rsp_ready) void'(iq.pop_front());
      if (ev_l && lsu_rsp_ready) void'(lq.pop_front());
      if (gi) iq.push_back(refmem[ifu_req_addr[5:0]]);
      if (gl) begin
        if (lsu_req_we) begin
          lq.push_back(32'h0);
          refmem[lsu_req_addr[5:0]] = merge(refmem[lsu_req_addr[5:0]], lsu_req_wdata, lsu_req_wem);
        end else begin
          lq.push_back(refmem[lsu_req_addr[5:0]]);
        end
      end
      if (gi) starve = 0;
      else if (ifu_req_valid && starve < SMAX) starve++;
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/itcm_arb.md
# itcm_arb

Two-port arbiter and sequencer for the ITCM RAM instance. It shares the single-port RAM between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It routes the one-cycle-latency read data back to the granted requester and holds each response in a skid register under back-pressure. It sits between the core pipeline and the ITCM RAM wrapper.

## Interface
Parameters:
- `AW`, 14: word-address width, equal to `ITCM_RAM_AW`
- `DW`, 32: data width, equal to `ITCM_RAM_DW`
- `MW`, 4: write-mask width, equal to `ITCM_RAM_MW`
- `STARVE_MAX`, 4: consecutive IFU-blocked cycles before the IFU gets forced priority (1..15)

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ifu_req_valid` / `ifu_req_ready`  in / out  1  IFU request handshake
- `ifu_req_addr`  in  AW  IFU word address
- `ifu_rsp_valid` / `ifu_rsp_ready`  out / in  1  IFU response handshake
- `ifu_rsp_rdata`  out  DW  fetched word
- `lsu_req_valid` / `lsu_req_ready`  in / out  1  LSU request handshake
- `lsu_req_we`  in  1  1 = write
- `lsu_req_addr`  in  AW  LSU word address
- `lsu_req_wdata`  in  DW  write data
- `lsu_req_wem`  in  MW  byte write mask
- `lsu_rsp_valid` / `lsu_rsp_ready`  out / in  1  LSU response handshake; a response is issued for writes too
- `lsu_rsp_rdata`  out  DW  read data; 0 for a write response
- `ram_we`, `ram_addr`, `ram_din`, `ram_wem`  out  1/AW/DW/MW  to the RAM
- `ram_dout`  in  DW  RAM read data, valid one cycle after the address is sampled

## Operation
- A request is accepted when `valid && ready` at a clock edge. At most one port is granted per cycle, and `ready` goes high on the granted port only.
- A port is eligible when its `req_valid` is high and its response slot is not blocked. Blocked means `rsp_valid && !rsp_ready` in that cycle.
- Priority:
  - The LSU wins by default.
  - The IFU wins when `starve_cnt == STARVE_MAX`, or when the LSU is ineligible.
- `ram_*` outputs are combinational from the granted request. With no grant: `ram_we = 0`, `ram_wem = 0`, and `ram_addr`/`ram_din` are don't-care. An IFU grant drives `ram_we = 0`.
- State per port:
  - `pend`: a response is due in the next cycle.
  - `hold`: a response is parked in the skid register.
  - `hold_data` (DW): the parked data.
  - LSU only, `pend_wr`: the pending response is for a write.
- Response:
  - `rsp_valid = pend | hold`.
  - `rsp_rdata = hold ? hold_data : (pend_wr ? 0 : ram_dout)`.
  - When `pend && !rsp_ready`, capture the data into `hold_data` and set `hold`.
  - Clear `hold` on `rsp_ready`.
- Starvation counter `starve_cnt` (4 bits):
  - Increments, saturating at `STARVE_MAX`, in each cycle where `ifu_req_valid` is high and the IFU is not granted.
  - Clears on an IFU grant.
- Reset (asynchronous, any time, including mid-transaction):
  - `pend`, `hold`, `pend_wr`, `starve_cnt` and `hold_data` all go to 0.
  - All `ready`/`rsp_valid` outputs read 0 and `ram_we` reads 0 while `rst` is high.
  - An in-flight response is discarded.

## Timing
- Request accepted in cycle N → `rsp_valid` in cycle N+1, data driven directly from `ram_dout`.
- Under back-pressure, data stays stable from `hold_data` until `rsp_ready`.
- Throughput is one access per cycle overall, and one per cycle per port when `rsp_ready` is held high.
- A port whose response is accepted in cycle M may be granted again in cycle M; the unblock is combinational.
- A write hits the RAM at the acceptance edge. A read in the next cycle to the same address returns the new data.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: the LSU is granted.
- Simultaneous requests with `starve_cnt == STARVE_MAX`: the IFU is granted and the counter clears.

## Configuration
- `ITCM_ARB_FAIRNESS_EN` defined:
  - The starvation counter and forced IFU priority exist as described.
- `ITCM_ARB_FAIRNESS_EN` undefined:
  - Strict LSU priority; `starve_cnt` is not implemented.
  - The IFU is granted only when the LSU is ineligible.
  - `STARVE_MAX` is ignored.

## Test plan
- IFU-only read of addr 0x10 (preloaded 0xDEADBEEF), `rsp_ready = 1` → `ifu_req_ready` high in cycle N; `ifu_rsp_valid` with 0xDEADBEEF in N+1.
- LSU write 0x12345678 with `wem = 4'b0011` to addr 0x20 (old value 0xAAAAAAAA), then LSU read of 0x20 → write response rdata 0; read returns 0xAAAA5678.
- Both ports request every cycle with fairness on and `STARVE_MAX = 4` → grant pattern LSU×4, IFU, LSU×4, IFU. With the macro off → the IFU is never granted.
- IFU read with `ifu_rsp_ready` low for 3 cycles → `ifu_rsp_valid` and data stay stable; no new IFU grant until `ifu_rsp_ready`. The LSU is still granted meanwhile.
- Assert `rst` in the cycle after an accepted LSU read → `lsu_rsp_valid` reads 0 immediately, and stays 0 after release with no stale response.
- Back-to-back LSU reads of 0x00..0x07 with `rsp_ready` high → 8 responses in consecutive cycles, in order, with data matching the preload.
